// File: rtl/cpu_run_monitor_pkg.sv
// cpu_run_monitor_pkg: shared definitions for the cpu run-control/trace monitor
// Holds the verdict state encoding, the halt-loop instruction and the trace
// record layout {cycle, pc, inst} used by cpu_run_monitor and trace_fifo.
package cpu_run_monitor_pkg;
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_t;
  localparam logic [31:0] HALT_INST = 32'h0000006F;
  localparam int INST_W = 32;
  localparam int TREC_INST_LSB = 0;
  localparam int TREC_PC_LSB = INST_W;
  function automatic int trec_pc_msb(input int xlen);
    return TREC_PC_LSB + xlen - 1;
  endfunction
  function automatic int trec_cycle_lsb(input int xlen);
    return TREC_PC_LSB + xlen;
  endfunction
  function automatic int trec_w(input int cnt_w, input int xlen);
    return cnt_w + xlen + INST_W;
  endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: show-ahead ready/valid FIFO holding trace records
// Ports:
//   I_clk, I_rst (sync, active-low), I_push/I_data write side,
//   I_ready consumer accept, O_valid/O_data head record, O_overflow sticky loss flag.
// Configuration macro TRACE_OVERWRITE_EN: when defined, a push into a full FIFO
// without a pop replaces the oldest record; otherwise that push is dropped.
module trace_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 16
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_push,
  input  logic [WIDTH-1:0] I_data,
  input  logic             I_ready,
  output logic             O_valid,
  output logic [WIDTH-1:0] O_data,
  output logic             O_overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic r_ovf;
  logic w_full, w_pop, w_lost, w_wr_en, w_ovw;
  assign O_valid = r_cnt != '0;
  assign w_full = r_cnt == (AW+1)'(DEPTH);
  assign w_pop = O_valid && I_ready;
  // a push that finds the FIFO full with no pop in the same cycle loses a record
  assign w_lost = I_push && w_full && !w_pop;
`ifdef TRACE_OVERWRITE_EN
  // full means r_wr == r_rd, so the write lands on the oldest slot and r_rd steps past it
  assign w_wr_en = I_push;
  assign w_ovw = w_lost;
`else
  assign w_wr_en = I_push && !w_lost;
  assign w_ovw = 1'b0;
`endif
  always_ff @(posedge I_clk) begin
    if (!I_rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_wr <= r_wr + AW'(w_wr_en);
      r_rd <= r_rd + AW'(w_pop || w_ovw);
      r_cnt <= r_cnt + (AW+1)'(w_wr_en && !w_ovw) - (AW+1)'(w_pop);
      r_ovf <= r_ovf || w_lost;
    end
  end
  always_ff @(posedge I_clk) begin
    if (w_wr_en) r_mem[r_wr] <= I_data;
  end
  // head is gated so an empty FIFO presents zeros rather than stale RAM
  assign O_data = O_valid ? r_mem[r_rd] : '0;
  assign O_overflow = r_ovf;
endmodule

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: run-control verdict and per-cycle trace recorder beside the cpu core
// Ports:
//   I_clk, I_rst (sync, active-low)
//   I_pc, I_inst, I_memrw, I_memaddr, I_memwdata : cpu observation
//   I_trace_ready / O_trace_valid, O_trace_cycle, O_trace_pc, O_trace_inst : trace stream
//   O_state (00 RUN, 01 PASS, 10 FAIL, 11 TIMEOUT), O_done, O_fail_code, O_cycle, O_overflow
// Configuration macro TRACE_OVERWRITE_EN selects overwrite-oldest vs drop-newest
// behaviour of the trace FIFO when it is full.
module cpu_run_monitor
  import cpu_run_monitor_pkg::*;
#(
  parameter int               XLEN        = 32,
  parameter int               DEPTH       = 16,
  parameter int               CNT_W       = 32,
  parameter logic [CNT_W-1:0] MAX_CYCLES  = 1000,
  parameter int               HALT_REPEAT = 4,
  parameter logic [XLEN-1:0]  TOHOST_ADDR = XLEN'(32'h00001000)
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic [XLEN-1:0]  I_pc,
  input  logic [31:0]      I_inst,
  input  logic             I_memrw,
  input  logic [XLEN-1:0]  I_memaddr,
  input  logic [XLEN-1:0]  I_memwdata,
  input  logic             I_trace_ready,
  output logic             O_trace_valid,
  output logic [CNT_W-1:0] O_trace_cycle,
  output logic [XLEN-1:0]  O_trace_pc,
  output logic [31:0]      O_trace_inst,
  output logic [1:0]       O_state,
  output logic             O_done,
  output logic [XLEN-1:0]  O_fail_code,
  output logic [CNT_W-1:0] O_cycle,
  output logic             O_overflow
);
  localparam int TREC_W = trec_w(CNT_W, XLEN);
  localparam int CYC_LSB = trec_cycle_lsb(XLEN);
  localparam int PC_MSB = trec_pc_msb(XLEN);
  localparam int RW = $clog2(HALT_REPEAT) + 1;
  localparam logic [CNT_W-1:0] LAST_CYCLE = MAX_CYCLES - 1'b1;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cycle;
  logic [XLEN-1:0] r_prev_pc, r_fail;
  logic [RW-1:0] r_rep;
  logic w_run, w_tohost, w_loop, w_halt, w_timeout;
  logic [TREC_W-1:0] w_rec, w_head;
  assign w_run = r_state == ST_RUN;
  assign w_tohost = I_memrw && I_memaddr == TOHOST_ADDR && I_memwdata != '0;
  assign w_loop = I_inst == HALT_INST && I_pc == r_prev_pc;
  // this loop cycle is the one that brings the repeat count to HALT_REPEAT-1
  assign w_halt = w_loop && r_rep == RW'(HALT_REPEAT - 2);
  assign w_timeout = r_cycle == LAST_CYCLE;
  always_ff @(posedge I_clk) begin
    if (!I_rst) r_state <= ST_RUN;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = !w_run    ? r_state :
             w_tohost  ? (I_memwdata == XLEN'(1) ? ST_PASS : ST_FAIL) :
             w_halt    ? ST_PASS :
             w_timeout ? ST_TIMEOUT : ST_RUN;
  end
  always_comb begin
    O_state = r_state;
    O_done = r_state != ST_RUN;
    O_fail_code = r_fail;
    O_cycle = r_cycle;
  end
  always_ff @(posedge I_clk) begin
    if (!I_rst) begin
      r_cycle <= '0;
      r_prev_pc <= '0;
      r_fail <= '0;
      r_rep <= '0;
    end else begin
      r_prev_pc <= I_pc;
      if (w_run) begin
        r_cycle <= r_cycle == '1 ? r_cycle : r_cycle + 1'b1;
        r_rep <= w_loop ? r_rep + 1'b1 : '0;
        if (w_next == ST_FAIL) r_fail <= I_memwdata >> 1;
      end
    end
  end
  assign w_rec = {r_cycle, I_pc, I_inst};
  trace_fifo #(.WIDTH(TREC_W), .DEPTH(DEPTH)) u_fifo (
    .I_clk(I_clk),
    .I_rst(I_rst),
    .I_push(w_run),
    .I_data(w_rec),
    .I_ready(I_trace_ready),
    .O_valid(O_trace_valid),
    .O_data(w_head),
    .O_overflow(O_overflow)
  );
  assign O_trace_inst = w_head[TREC_INST_LSB +: INST_W];
  assign O_trace_pc = w_head[PC_MSB:TREC_PC_LSB];
  assign O_trace_cycle = w_head[TREC_W-1:CYC_LSB];
endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb_cpu_run_monitor: directed bench with a queue-based reference model for cpu_run_monitor
module tb_cpu_run_monitor;
  localparam int DEPTH = 16;
  localparam int HALT_REPEAT = 4;
  localparam int MAXC [2] = '{1000, 10};
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] JSELF = 32'h0000006F;
  logic clk = 0, rst = 0, memrw = 0, ready = 1;
  logic [31:0] pc = 0, inst = 0, addr = 0, wdata = 0;
  logic [1:0] st [2];
  logic dn [2], vld [2], ov [2];
  logic [31:0] fc [2], cy [2], tc [2], tpc [2], ti [2];
  int n_tests = 0, n_fail = 0, n_drain = 0;
  logic [31:0] heads [$];
  int m_st [2], m_rep [2];
  logic [31:0] m_cyc [2], m_fc [2], m_prev;
  logic m_ovf [2];
  logic [95:0] mq [2][$];
  always #5 clk = ~clk;
  cpu_run_monitor dut (
    .I_clk(clk), .I_rst(rst), .I_pc(pc), .I_inst(inst), .I_memrw(memrw),
    .I_memaddr(addr), .I_memwdata(wdata), .I_trace_ready(ready),
    .O_trace_valid(vld[0]), .O_trace_cycle(tc[0]), .O_trace_pc(tpc[0]),
    .O_trace_inst(ti[0]), .O_state(st[0]), .O_done(dn[0]),
    .O_fail_code(fc[0]), .O_cycle(cy[0]), .O_overflow(ov[0])
  );
  cpu_run_monitor #(.MAX_CYCLES(10)) dut_to (
    .I_clk(clk), .I_rst(rst), .I_pc(pc), .I_inst(inst), .I_memrw(memrw),
    .I_memaddr(addr), .I_memwdata(wdata), .I_trace_ready(ready),
    .O_trace_valid(vld[1]), .O_trace_cycle(tc[1]), .O_trace_pc(tpc[1]),
    .O_trace_inst(ti[1]), .O_state(st[1]), .O_done(dn[1]),
    .O_fail_code(fc[1]), .O_cycle(cy[1]), .O_overflow(ov[1])
  );
  // reference model: verdict rules applied directly, trace kept as a queue of records
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [95:0] rec;
      if (!rst) begin
        m_st[k] = 0; m_cyc[k] = 0; m_fc[k] = 0; m_rep[k] = 0; m_ovf[k] = 0;
        mq[k].delete();
      end else begin
        if (ready && mq[k].size() > 0) void'(mq[k].pop_front());
        if (m_st[k] == 0) begin
          rec = {m_cyc[k], pc, inst};
          if (mq[k].size() < DEPTH) mq[k].push_back(rec);
          else begin
            m_ovf[k] = 1;
`ifdef TRACE_OVERWRITE_EN
            void'(mq[k].pop_front());
            mq[k].push_back(rec);
`endif
          end
          m_rep[k] = (inst == JSELF && pc == m_prev) ? m_rep[k] + 1 : 0;
          if (memrw && addr == 32'h1000 && wdata != 0) begin
            m_st[k] = (wdata == 1) ? 1 : 2;
            m_fc[k] = (wdata == 1) ? 0 : wdata >> 1;
          end else if (m_rep[k] == HALT_REPEAT - 1) m_st[k] = 1;
          else if (m_cyc[k] == MAXC[k] - 1) m_st[k] = 3;
          m_cyc[k] = m_cyc[k] + 1;
        end
      end
    end
    m_prev = rst ? pc : 32'h0;
  end
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got %h want %h", nm, k, act, exp);
    end
  endtask
  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      logic [95:0] h;
      h = mq[k].size() != 0 ? mq[k][0] : 96'h0;
      chk("state", k, 32'(st[k]), 32'(m_st[k]));
      chk("done", k, 32'(dn[k]), 32'(m_st[k] != 0));
      chk("fail_code", k, fc[k], m_fc[k]);
      chk("cycle", k, cy[k], m_cyc[k]);
      chk("overflow", k, 32'(ov[k]), 32'(m_ovf[k]));
      chk("valid", k, 32'(vld[k]), 32'(mq[k].size() != 0));
      chk("trace_cycle", k, tc[k], h[95:64]);
      chk("trace_pc", k, tpc[k], h[63:32]);
      chk("trace_inst", k, ti[k], h[31:0]);
    end
  endtask
  task automatic step(input logic [31:0] p, input logic [31:0] i, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    pc = p; inst = i; memrw = w; addr = a; wdata = d;
    if (vld[1] && ready) n_drain++;
    if (vld[0] && ready) heads.push_back(tc[0]);
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask
  task automatic do_reset();
    rst = 0;
    repeat (3) step(0, NOP, 0, 0, 0);
    rst = 1;
  endtask
  initial begin
    @(negedge clk);
    ready = 1;
    do_reset();
    chk("rst_state", 0, 32'(st[0]), 0);
    chk("rst_valid", 0, 32'(vld[0]), 0);
    step(32'h0, NOP, 0, 0, 0);
    chk("t1_c0", 0, tc[0], 0); chk("t1_p0", 0, tpc[0], 32'h0);
    step(32'h4, NOP, 0, 0, 0);
    chk("t1_c1", 0, tc[0], 1); chk("t1_p1", 0, tpc[0], 32'h4);
    step(32'h8, NOP, 0, 0, 0);
    chk("t1_c2", 0, tc[0], 2); chk("t1_p2", 0, tpc[0], 32'h8);
    chk("t1_state", 0, 32'(st[0]), 0);
    step(32'hC, NOP, 0, 0, 0);
    step(32'h10, NOP, 0, 0, 0);
    step(32'h14, 32'h00102023, 1, 32'h1000, 1);
    chk("t2_state", 0, 32'(st[0]), 1);
    chk("t2_cycle", 0, cy[0], 6);
    chk("t2_rec", 0, tc[0], 5);
    step(32'h18, NOP, 0, 0, 0);
    chk("t2_frozen", 0, cy[0], 6);
    do_reset();
    step(32'h0, NOP, 0, 0, 0);
    step(32'h4, NOP, 0, 0, 0);
    step(32'h8, 32'h00702023, 1, 32'h1000, 7);
    chk("t3_state", 0, 32'(st[0]), 2);
    chk("t3_code", 0, fc[0], 3);
    do_reset();
    step(32'h0, NOP, 0, 0, 0);
    step(32'h4, 32'h00002023, 1, 32'h1000, 0);
    chk("t4_store0", 0, 32'(st[0]), 0);
    repeat (3) step(32'h40, JSELF, 0, 0, 0);
    chk("t4_pre", 0, 32'(st[0]), 0);
    step(32'h40, JSELF, 0, 0, 0);
    chk("t4_pass", 0, 32'(st[0]), 1);
    do_reset();
    n_drain = 0;
    for (int n = 0; n < 10; n++) step(32'(4 * n), NOP, 0, 0, 0);
    chk("t5_state", 1, 32'(st[1]), 3);
    chk("t5_cycle", 1, cy[1], 10);
    step(32'h28, NOP, 0, 0, 0);
    step(32'h2C, NOP, 0, 0, 0);
    chk("t5_drained", 1, 32'(n_drain), 10);
    chk("t5_other", 0, 32'(st[0]), 0);
    do_reset();
    ready = 0;
    for (int n = 0; n < 20; n++) step(32'(4 * n), NOP, 0, 0, 0);
    chk("t6_ovf", 0, 32'(ov[0]), 1);
    chk("t6_ovf_to", 1, 32'(ov[1]), 0);
`ifdef TRACE_OVERWRITE_EN
    chk("t6_head", 0, tc[0], 4);
`else
    chk("t6_head", 0, tc[0], 0);
`endif
    ready = 1;
    heads.delete();
    for (int n = 20; n < 36; n++) step(32'(4 * n), NOP, 0, 0, 0);
    chk("t6_ndrain", 0, 32'(heads.size()), 16);
`ifdef TRACE_OVERWRITE_EN
    chk("t6_tail", 0, heads.size() == 16 ? heads[15] : 32'hFFFFFFFF, 19);
`else
    chk("t6_tail", 0, heads.size() == 16 ? heads[15] : 32'hFFFFFFFF, 15);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
